cond_exec_sequencer: RTL and testbench
======================================

// Module: cond_exec_sequencer
// PURPOSE
//  Sequences conditional execution in front of the condition tester datapath.
//  Holds the architectural NZCV flag register and accepts one instruction at a time.
//  Stalls while a flag-setting instruction is still in flight, then issues a
//  one-cycle GO (condition passed) or SQUASH (condition failed) to the control unit.
//  Sits between the instruction register and the execute-stage control logic.
// PARAMETERS
//  TIMEOUT   15   max cycles spent in WAIT before forced squash (1..255)
//  CNT_W      8   width of the WAIT cycle counter; must hold TIMEOUT
// PORTS
//  clk            in   1   system clock, rising edge
//  reset_n        in   1   asynchronous active-low reset
//  ir_valid       in   1   instruction available on ir_cond / ir_sets_flags
//  ir_cond        in   4   ARM cond field, IR[31:28]
//  ir_sets_flags  in   1   instruction S bit: will write NZCV when it executes
//  ir_ready       out  1   sequencer accepts an instruction this cycle
//  alu_flags_valid in  1   ALU presents result flags of the pending instruction
//  alu_flags      in   4   {N,Z,C,V} from the ALU
//  exec_go        out  1   one-cycle pulse: condition passed, execute
//  exec_squash    out  1   one-cycle pulse: condition failed or timeout, treat as NOP
//  flags          out  4   current architectural {N,Z,C,V}
//  flags_pending  out  1   a flag-setting instruction issued, flags not yet returned
//  err_timeout    out  1   sticky: WAIT hit TIMEOUT; cleared only by reset
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE, flags=4'b0000, flags_pending=0, cnt=0, err_timeout=0
//   - exec_go=0, exec_squash=0, ir_ready=1
//  ir_ready=1 only in IDLE. Handshake is ir_valid&ir_ready at a rising edge;
//   accepted ir_cond / ir_sets_flags are latched into cond_q / sf_q.
//  FSM:
//   - IDLE -> EVAL on accept when flags_pending=0, or when alu_flags_valid=1 the same edge.
//   - IDLE -> WAIT on accept otherwise.
//   - WAIT: cnt increments every cycle.
//     - alu_flags_valid=1 -> EVAL.
//     - Else cnt==TIMEOUT-1 -> SQUASH_TO; sets err_timeout and clears flags_pending.
//   - EVAL, one cycle: pass=f(cond_q,flags).
//     - exec_go=pass, exec_squash=!pass.
//     - If pass&sf_q then flags_pending<=1.
//     - cnt<=0, -> IDLE.
//   - SQUASH_TO, one cycle: exec_squash=1, cnt<=0, -> IDLE.
//  Latency: accept at edge k, GO/SQUASH high during cycle k+1 when not stalled.
//   Minimum spacing between two accepted instructions is 2 cycles.
//  Flag update, any state:
//   - alu_flags_valid & flags_pending: flags<=alu_flags, flags_pending<=0.
//   - alu_flags_valid & !flags_pending: ignored, flags unchanged.
//   - An update and an EVAL-entry on the same edge: EVAL sees the new flags.
//  Condition table, pass by cond:
//   - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
//   - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
//   - E AL 1; F NV 0, always squashes
//  exec_go and exec_squash are mutually exclusive and are never high outside EVAL/SQUASH_TO.
//  Reset mid-WAIT or mid-EVAL: the in-flight instruction is dropped, no pulse, and all state returns to reset values.
// TESTING
//  - Reset, then accept cond=E, sf=0 -> exec_go=1 for 1 cycle at k+1; flags=0000; ir_ready back to 1 at k+2.
//  - Accept cond=0 (EQ) with flags=0000 -> exec_squash=1; then alu-seeded Z=1 path: issue cond=E sf=1 -> go, pending=1;
//    alu_flags=0100 valid -> flags=0100; cond=0 -> exec_go=1.
//  - Pending=1, accept cond=1 (NE) -> stays in WAIT, ir_ready=0; alu_flags=0000 valid after 3 cycles -> exec_go next cycle.
//  - Pending=1, no alu_flags_valid for TIMEOUT=15 cycles -> exec_squash=1, err_timeout=1 sticky, flags_pending=0.
//  - Sweep all 16 cond x 16 NZCV via preloaded flags -> go/squash matches table, e.g. cond=A (GE), flags=1001 -> go;
//    cond=F -> always squash.
//  - Assert reset_n=0 during WAIT -> no pulse, flags=0000, ir_ready=1 immediately; alu_flags_valid with pending=0 -> flags unchanged.

Source files
------------

// File: rtl/cond_exec_sequencer_if.sv
// Handshake and status bundle between the instruction register / ALU side and
// the conditional-execution sequencer.
interface cond_exec_sequencer_if;
  logic       ir_valid;
  logic [3:0] ir_cond;
  logic       ir_sets_flags;
  logic       ir_ready;
  logic       alu_flags_valid;
  logic [3:0] alu_flags;
  logic       exec_go;
  logic       exec_squash;
  logic [3:0] flags;
  logic       flags_pending;
  logic       err_timeout;

  modport master (
    output ir_valid, ir_cond, ir_sets_flags, alu_flags_valid, alu_flags,
    input  ir_ready, exec_go, exec_squash, flags, flags_pending, err_timeout
  );

  modport slave (
    input  ir_valid, ir_cond, ir_sets_flags, alu_flags_valid, alu_flags,
    output ir_ready, exec_go, exec_squash, flags, flags_pending, err_timeout
  );
endinterface

// File: rtl/cond_exec_sequencer.sv
// Conditional-execution sequencer: owns the NZCV register, stalls on in-flight
// flag writers and issues a one-cycle GO or SQUASH per accepted instruction.
module cond_exec_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cond_exec_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EVAL,
    SQUASH_TO
  } state_t;

  state_t           state;
  logic [3:0]       cond_q;
  logic             sf_q;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       flags_q;
  logic             pending_q;
  logic             err_q;
  logic             go_q;
  logic             squash_q;

  logic             accept;
  logic             flag_update;
  logic [3:0]       flags_next;
  logic [3:0]       eval_cond;
  logic             eval_pass;
  logic             timeout_hit;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'h0:    pass = z;
      4'h1:    pass = !z;
      4'h2:    pass = c;
      4'h3:    pass = !c;
      4'h4:    pass = n;
      4'h5:    pass = !n;
      4'h6:    pass = v;
      4'h7:    pass = !v;
      4'h8:    pass = c && !z;
      4'h9:    pass = !c || z;
      4'hA:    pass = (n == v);
      4'hB:    pass = (n != v);
      4'hC:    pass = !z && (n == v);
      4'hD:    pass = z || (n != v);
      4'hE:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // The condition is evaluated on the edge that enters EVAL, against the flags
  // that edge will write, so a same-edge ALU update is seen by the instruction.
  always_comb begin
    accept      = bus.ir_valid && (state == IDLE);
    flag_update = bus.alu_flags_valid && pending_q;
    flags_next  = flag_update ? bus.alu_flags : flags_q;
    eval_cond   = (state == IDLE) ? bus.ir_cond : cond_q;
    eval_pass   = cond_pass(eval_cond, flags_next);
    timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  end

  // NOTE: all state here uses non-blocking assignments; several branches may
  // assign pending_q on one edge and the last assignment in program order wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cond_q    <= '0;
      sf_q      <= 1'b0;
      cnt       <= '0;
      flags_q   <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      go_q      <= 1'b0;
      squash_q  <= 1'b0;
    end else begin
      go_q     <= 1'b0;
      squash_q <= 1'b0;

      if (flag_update) begin
        flags_q   <= bus.alu_flags;
        pending_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            cond_q <= bus.ir_cond;
            sf_q   <= bus.ir_sets_flags;
            if (!pending_q || bus.alu_flags_valid) begin
              state    <= EVAL;
              go_q     <= eval_pass;
              squash_q <= !eval_pass;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (bus.alu_flags_valid) begin
            state    <= EVAL;
            go_q     <= eval_pass;
            squash_q <= !eval_pass;
          end else if (timeout_hit) begin
            state     <= SQUASH_TO;
            squash_q  <= 1'b1;
            err_q     <= 1'b1;
            pending_q <= 1'b0;
          end
        end

        EVAL: begin
          // go_q holds this instruction's pass result for the whole EVAL cycle.
          if (go_q && sf_q) begin
            pending_q <= 1'b1;
          end
          cnt   <= '0;
          state <= IDLE;
        end

        SQUASH_TO: begin
          cnt   <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ir_ready      = (state == IDLE);
  assign bus.exec_go       = go_q;
  assign bus.exec_squash   = squash_q;
  assign bus.flags         = flags_q;
  assign bus.flags_pending = pending_q;
  assign bus.err_timeout   = err_q;

endmodule

// File: tb/tb_cond_exec_sequencer.sv
// Directed bench for cond_exec_sequencer: handshake latency, flag stall,
// timeout, full condition sweep and mid-WAIT reset.
module tb_cond_exec_sequencer;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   pulses;

  cond_exec_sequencer_if bus ();

  cond_exec_sequencer #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ARM-style evaluation: base condition from cond[3:1], inverted by cond[0].
  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  // Called at a falling edge with the sequencer idle; returns two cycles later.
  task automatic issue(input logic [3:0] c, input logic sf, input logic exp_go, input string tag);
    check({tag, "_ready_in"}, 32'(bus.ir_ready), 32'd1);
    bus.ir_valid      = 1'b1;
    bus.ir_cond       = c;
    bus.ir_sets_flags = sf;
    @(negedge clk);
    bus.ir_valid = 1'b0;
    check({tag, "_go"},     32'(bus.exec_go),     32'(exp_go));
    check({tag, "_squash"}, 32'(bus.exec_squash), 32'(!exp_go));
    check({tag, "_busy"},   32'(bus.ir_ready),    32'd0);
    @(negedge clk);
    check({tag, "_ready_out"}, 32'(bus.ir_ready), 32'd1);
    check({tag, "_quiet"}, 32'(bus.exec_go | bus.exec_squash), 32'd0);
  endtask

  task automatic push_flags(input logic [3:0] f);
    bus.alu_flags_valid = 1'b1;
    bus.alu_flags       = f;
    @(negedge clk);
    bus.alu_flags_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.ir_valid        = 1'b0;
    bus.ir_cond         = 4'h0;
    bus.ir_sets_flags   = 1'b0;
    bus.alu_flags_valid = 1'b0;
    bus.alu_flags       = 4'h0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",   32'(bus.ir_ready),      32'd1);
    check("rst_flags",   32'(bus.flags),         32'h0);
    check("rst_pending", 32'(bus.flags_pending), 32'd0);
    check("rst_err",     32'(bus.err_timeout),   32'd0);
    check("rst_go",      32'(bus.exec_go),       32'd0);
    check("rst_squash",  32'(bus.exec_squash),   32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Always-condition, then EQ against Z=0.
    issue(4'hE, 1'b0, 1'b1, "al");
    check("al_flags", 32'(bus.flags), 32'h0);
    issue(4'h0, 1'b0, 1'b0, "eq_z0");

    // Flag writer, ALU returns Z=1, then EQ passes.
    issue(4'hE, 1'b1, 1'b1, "setz");
    check("setz_pending", 32'(bus.flags_pending), 32'd1);
    push_flags(4'b0100);
    check("setz_flags",   32'(bus.flags),         32'h4);
    check("setz_cleared", 32'(bus.flags_pending), 32'd0);
    issue(4'h0, 1'b0, 1'b1, "eq_z1");

    // Stall in WAIT, flags arrive on the fourth cycle.
    issue(4'hE, 1'b1, 1'b1, "stall_w");
    bus.ir_valid = 1'b1; bus.ir_cond = 4'h1; bus.ir_sets_flags = 1'b0;
    @(negedge clk);
    bus.ir_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      check("stall_busy", 32'(bus.ir_ready), 32'd0);
      pulses += int'(bus.exec_go | bus.exec_squash);
      if (i < 2) @(negedge clk);
    end
    check("stall_nopulse", 32'(pulses), 32'd0);
    push_flags(4'b0000);
    check("stall_go",      32'(bus.exec_go),       32'd1);
    check("stall_squash",  32'(bus.exec_squash),   32'd0);
    check("stall_flags",   32'(bus.flags),         32'h0);
    check("stall_pending", 32'(bus.flags_pending), 32'd0);
    @(negedge clk);
    check("stall_ready", 32'(bus.ir_ready), 32'd1);

    // Flags arrive on the same edge as the accept: EQ sees the new Z.
    issue(4'hE, 1'b1, 1'b1, "same_w");
    bus.ir_valid = 1'b1; bus.ir_cond = 4'h0; bus.ir_sets_flags = 1'b0;
    bus.alu_flags_valid = 1'b1; bus.alu_flags = 4'b0100;
    @(negedge clk);
    bus.ir_valid = 1'b0; bus.alu_flags_valid = 1'b0;
    check("same_go",    32'(bus.exec_go), 32'd1);
    check("same_flags", 32'(bus.flags),   32'h4);
    @(negedge clk);
    push_flags(4'b0000);
    check("same_reload", 32'(bus.flags), 32'h4);

    // Timeout: 15 WAIT cycles with no ALU flags.
    issue(4'hE, 1'b1, 1'b1, "to_w");
    bus.ir_valid = 1'b1; bus.ir_cond = 4'hE; bus.ir_sets_flags = 1'b0;
    @(negedge clk);
    bus.ir_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      pulses += int'(bus.exec_go | bus.exec_squash);
      @(negedge clk);
    end
    check("to_nopulse", 32'(pulses),            32'd0);
    check("to_squash",  32'(bus.exec_squash),   32'd1);
    check("to_go",      32'(bus.exec_go),       32'd0);
    check("to_err",     32'(bus.err_timeout),   32'd1);
    check("to_pending", 32'(bus.flags_pending), 32'd0);
    @(negedge clk);
    check("to_ready", 32'(bus.ir_ready), 32'd1);
    issue(4'h0, 1'b0, 1'b1, "to_after");
    check("to_sticky", 32'(bus.err_timeout), 32'd1);

    // Full cond x NZCV sweep, flags preloaded through the ALU path.
    for (int f = 0; f < 16; f++) begin
      issue(4'hE, 1'b1, 1'b1, "sw_load");
      push_flags(4'(f));
      check("sw_flags", 32'(bus.flags), 32'(f));
      for (int c = 0; c < 16; c++) begin
        issue(4'(c), 1'b0, model_pass(4'(c), 4'(f)), $sformatf("sw_c%0h_f%0h", c, f));
      end
    end
    issue(4'hF, 1'b0, 1'b0, "nv_final");

    // Reset while stalled in WAIT.
    issue(4'hE, 1'b1, 1'b1, "rw_w");
    bus.ir_valid = 1'b1; bus.ir_cond = 4'hE; bus.ir_sets_flags = 1'b0;
    @(negedge clk);
    bus.ir_valid = 1'b0;
    check("rw_waiting", 32'(bus.ir_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rw_ready",   32'(bus.ir_ready),      32'd1);
    check("rw_flags",   32'(bus.flags),         32'h0);
    check("rw_pending", 32'(bus.flags_pending), 32'd0);
    check("rw_err",     32'(bus.err_timeout),   32'd0);
    check("rw_pulse",   32'(bus.exec_go | bus.exec_squash), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pulses += int'(bus.exec_go | bus.exec_squash);
    end
    check("rw_nopulse", 32'(pulses), 32'd0);
    push_flags(4'b1111);
    check("rw_ignored", 32'(bus.flags), 32'h0);
    issue(4'hE, 1'b0, 1'b1, "rw_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
